dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port byte-addressed data memory (DMEM).
- Requesters: core load/store path (core_*) and debug/program-loader port (dbg_*).
- Grants one access at a time, drives the DMEM control/address/data pins from registers, captures read data, and returns a one-cycle response with an error flag.
- Rejects misaligned, out-of-range and malformed accesses before they reach DMEM.

---
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (core, debug) arbiter and sequencer for the single-port byte-addressed DMEM.
// One access per three cycles: grant in IDLE, drive DMEM in ACCESS, respond in RESP.
module dmem_arbiter #(
  parameter int DEPTH      = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_load_type,
  input  logic [1:0]  core_store_type,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,

  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_load_type,
  input  logic [1:0]  dbg_store_type,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,

  output logic        MemRW,
  output logic [2:0]  Load_type,
  output logic [1:0]  Store_type,
  output logic [31:0] DataW,
  output logic [31:0] addr,
  input  logic [31:0] DMEMout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          mem_we_q;
  logic          owner_dbg;
  logic          resp_we;
  logic          resp_err;

  logic          core_win;
  logic          dbg_win;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [2:0]    sel_lt;
  logic [1:0]    sel_st;
  logic          sel_err;

  // Size/alignment/range check; size 0 marks an unknown type encoding.
  function automatic logic access_err(input logic we, input logic [31:0] a,
                                      input logic [2:0] lt, input logic [1:0] st);
    logic [2:0] size;
    logic       bad;
    size = 3'd0;
    bad  = 1'b0;
    if (we) begin
      case (st)
        2'd1:    size = 3'd1;
        2'd2:    size = 3'd2;
        2'd3:    size = 3'd4;
        default: bad  = 1'b1;
      endcase
    end else begin
      case (lt)
        3'd1, 3'd4: size = 3'd1;
        3'd2, 3'd5: size = 3'd2;
        3'd3:       size = 3'd4;
        default:    bad  = 1'b1;
      endcase
    end
    if (size == 3'd4 && a[1:0] != 2'b00) bad = 1'b1;
    if (size == 3'd2 && a[0]) bad = 1'b1;
    if (!bad && ({1'b0, a} + 33'(size) - 33'd1 >= 33'(DEPTH))) bad = 1'b1;
    return bad;
  endfunction

  // Core wins unless debug has been starved for STARVE_MAX core grants.
  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (state == IDLE && !rst) begin
      if (dbg_req && (!core_req || starve_cnt == CW'(STARVE_MAX))) dbg_win = 1'b1;
      else if (core_req) core_win = 1'b1;
    end
  end

  always_comb begin
    sel_we    = dbg_win ? dbg_we         : core_we;
    sel_addr  = dbg_win ? dbg_addr       : core_addr;
    sel_wdata = dbg_win ? dbg_wdata      : core_wdata;
    sel_lt    = dbg_win ? dbg_load_type  : core_load_type;
    sel_st    = dbg_win ? dbg_store_type : core_store_type;
    sel_err   = access_err(sel_we, sel_addr, sel_lt, sel_st);
  end

  assign core_gnt = core_win;
  assign dbg_gnt  = dbg_win;
  assign MemRW    = mem_we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_we_q    <= 1'b0;
      owner_dbg   <= 1'b0;
      resp_we     <= 1'b0;
      resp_err    <= 1'b0;
      Load_type   <= 3'd0;
      Store_type  <= 2'd0;
      DataW       <= 32'd0;
      addr        <= 32'd0;
      core_rvalid <= 1'b0;
      core_rdata  <= 32'd0;
      core_err    <= 1'b0;
      dbg_rvalid  <= 1'b0;
      dbg_rdata   <= 32'd0;
      dbg_err     <= 1'b0;
    end else begin
      if (!dbg_req || dbg_win) starve_cnt <= '0;
      else if (core_win && starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);

      case (state)
        IDLE: begin
          if (core_win || dbg_win) begin
            state      <= ACCESS;
            owner_dbg  <= dbg_win;
            resp_we    <= sel_we;
            resp_err   <= sel_err;
            mem_we_q   <= sel_we && !sel_err;
            Load_type  <= (!sel_we && !sel_err) ? sel_lt : 3'd0;
            Store_type <= (sel_we && !sel_err) ? sel_st : 2'd0;
            DataW      <= (sel_we && !sel_err) ? sel_wdata : 32'd0;
            addr       <= sel_err ? 32'd0 : sel_addr;
          end
        end
        ACCESS: begin
          state       <= RESP;
          mem_we_q    <= 1'b0;
          Load_type   <= 3'd0;
          Store_type  <= 2'd0;
          DataW       <= 32'd0;
          addr        <= 32'd0;
          core_rvalid <= !owner_dbg;
          core_err    <= !owner_dbg && resp_err;
          core_rdata  <= (!owner_dbg && !resp_err && !resp_we) ? DMEMout : 32'd0;
          dbg_rvalid  <= owner_dbg;
          dbg_err     <= owner_dbg && resp_err;
          dbg_rdata   <= (owner_dbg && !resp_err && !resp_we) ? DMEMout : 32'd0;
        end
        RESP: begin
          state       <= IDLE;
          core_rvalid <= 1'b0;
          core_err    <= 1'b0;
          core_rdata  <= 32'd0;
          dbg_rvalid  <= 1'b0;
          dbg_err     <= 1'b0;
          dbg_rdata   <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural DMEM, transaction-level reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;
  localparam int DEPTH      = 256;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [2:0]  core_load_type, dbg_load_type;
  logic [1:0]  core_store_type, dbg_store_type;
  logic        core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] core_rdata, dbg_rdata;
  logic        MemRW;
  logic [2:0]  Load_type;
  logic [1:0]  Store_type;
  logic [31:0] DataW, addr, DMEMout;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_load_type(core_load_type), .core_store_type(core_store_type),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_load_type(dbg_load_type), .dbg_store_type(dbg_store_type),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .MemRW(MemRW), .Load_type(Load_type), .Store_type(Store_type),
    .DataW(DataW), .addr(addr), .DMEMout(DMEMout)
  );

  always #5 clk = ~clk;

  // Behavioural DMEM: combinational extending read, byte-lane write at the clock edge.
  logic [7:0] dmem [0:255];
  logic [7:0] rb0, rb1, rb2, rb3;

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    dmem[0] = 8'h05;
  end

  always_comb begin
    rb0 = dmem[addr[7:0]];
    rb1 = dmem[addr[7:0] + 8'd1];
    rb2 = dmem[addr[7:0] + 8'd2];
    rb3 = dmem[addr[7:0] + 8'd3];
    case (Load_type)
      3'd1:    DMEMout = {{24{rb0[7]}}, rb0};
      3'd2:    DMEMout = {{16{rb1[7]}}, rb1, rb0};
      3'd3:    DMEMout = {rb3, rb2, rb1, rb0};
      3'd4:    DMEMout = {24'd0, rb0};
      3'd5:    DMEMout = {16'd0, rb1, rb0};
      default: DMEMout = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (MemRW) begin
      dmem[addr[7:0]] <= DataW[7:0];
      if (Store_type >= 2'd2) dmem[addr[7:0] + 8'd1] <= DataW[15:8];
      if (Store_type == 2'd3) begin
        dmem[addr[7:0] + 8'd2] <= DataW[23:16];
        dmem[addr[7:0] + 8'd3] <= DataW[31:24];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus arithmetic rules for legality and data.
  logic [7:0] shadow [0:255];
  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    shadow[0] = 8'h05;
  end

  function automatic int access_bytes(input bit we, input logic [2:0] lt, input logic [1:0] st);
    if (we) return (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : (st == 2'd3) ? 4 : 0;
    return (lt == 3'd1 || lt == 3'd4) ? 1 : (lt == 3'd2 || lt == 3'd5) ? 2 : (lt == 3'd3) ? 4 : 0;
  endfunction

  function automatic bit model_err(input bit we, input logic [31:0] a,
                                   input logic [2:0] lt, input logic [1:0] st);
    int nb;
    nb = access_bytes(we, lt, st);
    if (nb == 0) return 1'b1;
    if (longint'(a) % nb != 0) return 1'b1;
    if (longint'(a) + nb > DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] lt);
    int i;
    logic [31:0] w;
    i = int'(a);
    w = 32'd0;
    for (int k = 0; k < access_bytes(1'b0, lt, 2'd0); k++) w[8*k +: 8] = shadow[i + k];
    case (lt)
      3'd1:    return 32'($signed(w[7:0]));
      3'd2:    return 32'($signed(w[15:0]));
      default: return w;
    endcase
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] st, input logic [31:0] wd);
    for (int k = 0; k < access_bytes(1'b1, 3'd0, st); k++) shadow[int'(a) + k] = wd[8*k +: 8];
  endfunction

  int          mcyc = 0;
  int          free_at = 0;
  int          starve = 0;
  bit          inf_valid = 0;
  int          inf_cyc;
  bit          inf_dbg, inf_we, inf_err;
  logic [31:0] inf_addr, inf_wdata, inf_rdata;
  logic [2:0]  inf_lt;
  logic [1:0]  inf_st;
  bit          grant_log [$];

  always @(negedge clk) begin
    bit exp_mw, exp_crv, exp_drv, exp_cg, exp_dg, exp_err;
    logic [31:0] exp_rd;
    mcyc++;
    if (rst) begin
      checkOutput("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
      checkOutput("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
      checkOutput("rst_MemRW", {31'd0, MemRW}, 32'd0);
      inf_valid = 0;
      starve    = 0;
      free_at   = mcyc + 1;
    end else begin
      exp_mw = 0; exp_crv = 0; exp_drv = 0; exp_cg = 0; exp_dg = 0; exp_err = 0; exp_rd = 32'd0;
      if (inf_valid && mcyc == inf_cyc + 1) begin
        exp_mw    = inf_we && !inf_err;
        inf_rdata = 32'd0;
        if (!inf_err) checkOutput("access_addr", addr, inf_addr);
        if (!inf_err && !inf_we) begin
          checkOutput("access_load_type", {29'd0, Load_type}, {29'd0, inf_lt});
          inf_rdata = model_load(inf_addr, inf_lt);
        end
        if (!inf_err && inf_we) begin
          checkOutput("access_dataw", DataW, inf_wdata);
          model_store(inf_addr, inf_st, inf_wdata);
        end
      end
      if (inf_valid && mcyc == inf_cyc + 2) begin
        exp_crv   = !inf_dbg;
        exp_drv   = inf_dbg;
        exp_err   = inf_err;
        exp_rd    = inf_rdata;
        inf_valid = 0;
      end
      if (mcyc >= free_at && (core_req || dbg_req)) begin
        if (dbg_req && (!core_req || starve == STARVE_MAX)) exp_dg = 1;
        else exp_cg = 1;
        inf_valid = 1;
        inf_cyc   = mcyc;
        inf_dbg   = exp_dg;
        inf_we    = exp_dg ? dbg_we : core_we;
        inf_addr  = exp_dg ? dbg_addr : core_addr;
        inf_wdata = exp_dg ? dbg_wdata : core_wdata;
        inf_lt    = exp_dg ? dbg_load_type : core_load_type;
        inf_st    = exp_dg ? dbg_store_type : core_store_type;
        inf_err   = model_err(inf_we, inf_addr, inf_lt, inf_st);
        free_at   = mcyc + 3;
      end
      if (!dbg_req || exp_dg) starve = 0;
      else if (exp_cg) starve++;

      checkOutput("core_gnt", {31'd0, core_gnt}, {31'd0, exp_cg});
      checkOutput("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, exp_dg});
      checkOutput("MemRW", {31'd0, MemRW}, {31'd0, exp_mw});
      checkOutput("core_rvalid", {31'd0, core_rvalid}, {31'd0, exp_crv});
      checkOutput("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, exp_drv});
      if (exp_crv) begin
        checkOutput("core_err", {31'd0, core_err}, {31'd0, exp_err});
        checkOutput("core_rdata", core_rdata, exp_rd);
      end
      if (exp_drv) begin
        checkOutput("dbg_err", {31'd0, dbg_err}, {31'd0, exp_err});
        checkOutput("dbg_rdata", dbg_rdata, exp_rd);
      end
      if (core_gnt || dbg_gnt) grant_log.push_back(dbg_gnt);
    end
  end

  logic [31:0] last_rdata;
  bit          last_err, acc_memrw;
  logic [2:0]  acc_lt;
  int          gnt_wait, latency;

  task automatic applyStimulus(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] lt, input logic [1:0] st);
    bit got;
    if (d) begin
      dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_load_type = lt; dbg_store_type = st; dbg_req = 1;
    end else begin
      core_we = we; core_addr = a; core_wdata = wd; core_load_type = lt; core_store_type = st; core_req = 1;
    end
    got = 0;
    gnt_wait = 0;
    while (!got && gnt_wait < 20) begin
      @(negedge clk);
      gnt_wait++;
      if (d ? dbg_gnt : core_gnt) got = 1;
    end
    if (!got) checkOutput("gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (d) dbg_req = 0; else core_req = 0;
    @(negedge clk);
    acc_memrw = MemRW;
    acc_lt    = Load_type;
    latency   = 1;
    got       = 0;
    while (!got && latency < 12) begin
      @(negedge clk);
      latency++;
      if (d ? dbg_rvalid : core_rvalid) begin
        got        = 1;
        last_rdata = d ? dbg_rdata : core_rdata;
        last_err   = d ? dbg_err : core_err;
      end
    end
    if (!got) checkOutput("rvalid_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rv_seen;
    bit exp_order [10];
    bit got;
    rst = 1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_load_type = 0; core_store_type = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_load_type = 0; dbg_store_type = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("reset_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    checkOutput("reset_dbg_rdata", dbg_rdata, 32'd0);
    checkOutput("reset_addr", addr, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] store then load at addr 8");
    applyStimulus(0, 1, 32'd8, 32'hDEADBEEF, 3'd0, 2'd3);
    checkOutput("sw8_memrw_access", {31'd0, acc_memrw}, 32'd1);
    checkOutput("sw8_latency", latency, 32'd2);
    checkOutput("sw8_err", {31'd0, last_err}, 32'd0);
    checkOutput("sw8_rdata", last_rdata, 32'd0);
    applyStimulus(0, 0, 32'd8, 32'd0, 3'd3, 2'd0);
    checkOutput("lw8_rdata", last_rdata, 32'hDEADBEEF);
    checkOutput("lw8_err", {31'd0, last_err}, 32'd0);
    applyStimulus(0, 0, 32'd8, 32'd0, 3'd1, 2'd0);
    checkOutput("lb8_rdata", last_rdata, 32'hFFFFFFEF);

    $display("[TB] misaligned halfword load");
    applyStimulus(0, 0, 32'd5, 32'd0, 3'd2, 2'd0);
    checkOutput("lh5_memrw", {31'd0, acc_memrw}, 32'd0);
    checkOutput("lh5_load_type", {29'd0, acc_lt}, 32'd0);
    checkOutput("lh5_err", {31'd0, last_err}, 32'd1);
    checkOutput("lh5_rdata", last_rdata, 32'd0);

    $display("[TB] debug port range boundary");
    applyStimulus(1, 1, 32'd254, 32'hCAFEF00D, 3'd0, 2'd3);
    checkOutput("sw254_err", {31'd0, last_err}, 32'd1);
    checkOutput("sw254_memrw", {31'd0, acc_memrw}, 32'd0);
    applyStimulus(1, 1, 32'd255, 32'h0000007F, 3'd0, 2'd1);
    checkOutput("sb255_err", {31'd0, last_err}, 32'd0);
    applyStimulus(1, 0, 32'd255, 32'd0, 3'd4, 2'd0);
    checkOutput("lbu255_rdata", last_rdata, 32'h0000007F);
    applyStimulus(1, 0, 32'd256, 32'd0, 3'd4, 2'd0);
    checkOutput("lbu256_err", {31'd0, last_err}, 32'd1);

    $display("[TB] bad load type then immediate debug grant");
    applyStimulus(0, 0, 32'd4, 32'd0, 3'd6, 2'd0);
    checkOutput("lt6_err", {31'd0, last_err}, 32'd1);
    checkOutput("lt6_load_type", {29'd0, acc_lt}, 32'd0);
    applyStimulus(1, 0, 32'd0, 32'd0, 3'd3, 2'd0);
    checkOutput("dbg_after_err_gnt_wait", gnt_wait, 32'd1);
    checkOutput("dbg_lw0_rdata", last_rdata, 32'd5);

    $display("[TB] starvation order with both requesters held");
    grant_log.delete();
    core_we = 0; core_addr = 32'd8; core_load_type = 3'd3; core_store_type = 2'd0;
    dbg_we = 0; dbg_addr = 32'd0; dbg_load_type = 3'd5; dbg_store_type = 2'd0;
    core_req = 1;
    dbg_req = 1;
    for (int i = 0; i < 60 && grant_log.size() < 10; i++) @(negedge clk);
    @(posedge clk);
    #1;
    core_req = 0;
    dbg_req = 0;
    repeat (3) @(posedge clk);
    #1;
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    checkOutput("starve_grant_count", grant_log.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < grant_log.size())
        checkOutput($sformatf("starve_order_%0d", i), {31'd0, grant_log[i]}, {31'd0, exp_order[i]});

    $display("[TB] reset during store access");
    core_we = 1; core_addr = 32'd0; core_wdata = 32'h12345678; core_store_type = 2'd3; core_load_type = 3'd0;
    core_req = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (core_gnt) got = 1;
    end
    if (!got) checkOutput("rst_test_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    core_req = 0;
    rst = 1;
    @(negedge clk);
    checkOutput("rst_access_memrw", {31'd0, MemRW}, 32'd0);
    @(posedge clk);
    #1 rst = 0;
    rv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (core_rvalid) rv_seen++;
    end
    checkOutput("rst_dropped_rvalid", rv_seen, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 32'd0, 32'd0, 3'd3, 2'd0);
    checkOutput("post_rst_lw0", last_rdata, 32'h00000005);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
